// File: rtl/sc_io_display_scan.sv
`default_nettype none
// ============================================================================
// sc_io_display_scan : 6-digit multiplexed 7-segment scanner for IO ports 0..2
// Revision 1.0 - initial release
// ============================================================================
module sc_io_display_scan #(
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clock,
  input  logic        clrn,
  input  logic [31:0] out_port0,
  input  logic [31:0] out_port1,
  input  logic [31:0] out_port2,
  output logic [5:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        frame_tick
);

  localparam int            PW       = $clog2(SCAN_DIV) + 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [2:0]    DIG_LAST = 3'd5;

  logic [PW-1:0] pre_q, pre_d;
  logic [2:0]    dig_q, dig_d;
  logic [7:0]    snap0_q, snap0_d, snap1_q, snap1_d, snap2_q, snap2_d;
  logic [5:0]    an_n_q, an_n_d;
  logic [6:0]    seg_n_q, seg_n_d;
  logic          dp_n_q, dp_n_d;
  logic          frame_tick_q, frame_tick_d;

  logic          pre_wrap;
  logic          frame_end;
  logic          dig_valid;
  logic [7:0]    sel_byte;
  logic [3:0]    nibble;

  logic          unused_port_bits;
  assign unused_port_bits = ^{out_port0[31:8], out_port1[31:8], out_port2[31:8]};

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    pre_wrap  = (pre_q >= PRE_LAST);
    dig_valid = (dig_q <= DIG_LAST);
    frame_end = pre_wrap && (dig_q == DIG_LAST);

    pre_d = pre_wrap ? '0 : pre_q + PW'(1);

    dig_d = dig_q;
    if (!dig_valid || frame_end) begin
      dig_d = 3'd0;
    end else if (pre_wrap) begin
      dig_d = dig_q + 3'd1;
    end

    // Snapshot only at the frame boundary so a mid-frame store never tears the display
    snap0_d      = frame_end ? out_port0[7:0] : snap0_q;
    snap1_d      = frame_end ? out_port1[7:0] : snap1_q;
    snap2_d      = frame_end ? out_port2[7:0] : snap2_q;
    frame_tick_d = frame_end;

    case (dig_q[2:1])
      2'd0:    sel_byte = snap0_q;
      2'd1:    sel_byte = snap1_q;
      2'd2:    sel_byte = snap2_q;
      default: sel_byte = 8'h00;
    endcase
    nibble = dig_q[0] ? sel_byte[7:4] : sel_byte[3:0];

    an_n_d  = dig_valid ? ~(6'b000001 << dig_q) : 6'h3F;
    seg_n_d = hex7(nibble);
    if (!dig_valid || (BLANK_LZ && dig_q[0] && (nibble == 4'h0))) begin
      seg_n_d = 7'h7F;
    end
    dp_n_d = !((dig_q == 3'd2) || (dig_q == 3'd4));
  end

  always_ff @(posedge clock) begin
    if (!clrn) begin
      pre_q        <= '0;
      dig_q        <= 3'd0;
      snap0_q      <= 8'h00;
      snap1_q      <= 8'h00;
      snap2_q      <= 8'h00;
      an_n_q       <= 6'h3F;
      seg_n_q      <= 7'h7F;
      dp_n_q       <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      dig_q        <= dig_d;
      snap0_q      <= snap0_d;
      snap1_q      <= snap1_d;
      snap2_q      <= snap2_d;
      an_n_q       <= an_n_d;
      seg_n_q      <= seg_n_d;
      dp_n_q       <= dp_n_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign an_n       = an_n_q;
  assign seg_n      = seg_n_q;
  assign dp_n       = dp_n_q;
  assign frame_tick = frame_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_sc_io_display_scan.sv
`default_nettype none
// ============================================================================
// tb_sc_io_display_scan : directed table-driven bench for sc_io_display_scan
// Revision 1.0 - initial release
// ============================================================================
module tb_sc_io_display_scan;

  logic        clock = 1'b0;
  logic        clrn  = 1'b0;
  logic [31:0] out_port0 = '0, out_port1 = '0, out_port2 = '0;

  logic [5:0] an_n, an_n_nb, an_n_f;
  logic [6:0] seg_n, seg_n_nb, seg_n_f;
  logic       dp_n, dp_n_nb, dp_n_f;
  logic       frame_tick, frame_tick_nb, frame_tick_f;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  sc_io_display_scan #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clock(clock), .clrn(clrn), .out_port0(out_port0), .out_port1(out_port1),
    .out_port2(out_port2), .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n), .frame_tick(frame_tick));

  sc_io_display_scan #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_nb (
    .clock(clock), .clrn(clrn), .out_port0(out_port0), .out_port1(out_port1),
    .out_port2(out_port2), .an_n(an_n_nb), .seg_n(seg_n_nb), .dp_n(dp_n_nb),
    .frame_tick(frame_tick_nb));

  sc_io_display_scan #(.SCAN_DIV(1), .BLANK_LZ(1'b1)) dut_fast (
    .clock(clock), .clrn(clrn), .out_port0(out_port0), .out_port1(out_port1),
    .out_port2(out_port2), .an_n(an_n_f), .seg_n(seg_n_f), .dp_n(dp_n_f),
    .frame_tick(frame_tick_f));

  typedef struct packed {
    logic [31:0]     p0;
    logic [31:0]     p1;
    logic [31:0]     p2;
    logic [5:0][6:0] seg;  // expected seg_n per digit 0..5
    logic [6:0]      nb3;  // dig3 seg_n of the non-blanking instance
  } vec_t;

  localparam logic [5:0] AN_EXP [6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " an_n"}, 32'(an_n), 32'h3F);
    chk({tag, " seg_n"}, 32'(seg_n), 32'h7F);
    chk({tag, " dp_n"}, 32'(dp_n), 32'h1);
    chk({tag, " frame_tick"}, 32'(frame_tick), 32'h0);
  endtask

  // One 24-cycle frame: step s shows digit (s-1)/4; the tick lands on step 24.
  // chg_step>0 rewrites port1 right after that step.
  task automatic run_frame(input vec_t e, input int chg_step, input logic [31:0] chg_val);
    for (int s = 1; s <= 24; s++) begin
      int d;
      step();
      d = (s - 1) / 4;
      chk($sformatf("an_n d%0d", d), 32'(an_n), 32'(AN_EXP[d]));
      chk($sformatf("seg_n d%0d", d), 32'(seg_n), 32'(e.seg[d]));
      chk($sformatf("dp_n d%0d", d), 32'(dp_n), ((d == 2) || (d == 4)) ? 32'h0 : 32'h1);
      chk($sformatf("frame_tick s%0d", s), 32'(frame_tick), (s == 24) ? 32'h1 : 32'h0);
      if (s == 13) chk("nb seg_n d3", 32'(seg_n_nb), 32'(e.nb3));
      if (s == chg_step) out_port1 = chg_val;
    end
  endtask

  vec_t vecs [4];
  vec_t v_chg, v_zero;

  initial begin
    vecs[0] = '{p0: 32'h12, p1: 32'h34, p2: 32'hAB,
                seg: {7'h08, 7'h03, 7'h30, 7'h19, 7'h79, 7'h24}, nb3: 7'h30};
    vecs[1] = '{p0: 32'h00, p1: 32'h05, p2: 32'hF0,
                seg: {7'h0E, 7'h40, 7'h7F, 7'h12, 7'h7F, 7'h40}, nb3: 7'h40};
    vecs[2] = '{p0: 32'h9E, p1: 32'h00, p2: 32'h7C,
                seg: {7'h78, 7'h46, 7'h7F, 7'h40, 7'h10, 7'h06}, nb3: 7'h40};
    vecs[3] = '{p0: 32'hFFFFFF6D, p1: 32'h12345681, p2: 32'hABCDEF00,
                seg: {7'h7F, 7'h40, 7'h00, 7'h79, 7'h02, 7'h21}, nb3: 7'h00};
    v_chg   = '{p0: 32'h12, p1: 32'h56, p2: 32'hAB,
                seg: {7'h08, 7'h03, 7'h12, 7'h02, 7'h79, 7'h24}, nb3: 7'h12};
    v_zero  = '{p0: 32'h0, p1: 32'h0, p2: 32'h0,
                seg: {7'h7F, 7'h40, 7'h7F, 7'h40, 7'h7F, 7'h40}, nb3: 7'h40};

    // Reset held with all-ones ports
    out_port0 = 32'hFFFFFFFF; out_port1 = 32'hFFFFFFFF; out_port2 = 32'hFFFFFFFF;
    clrn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_reset_outputs("reset");
    end

    // Frame 0 shows the zero snapshot; also check the SCAN_DIV=1 instance
    out_port0 = vecs[0].p0; out_port1 = vecs[0].p1; out_port2 = vecs[0].p2;
    clrn = 1'b1;
    for (int s = 1; s <= 24; s++) begin
      step();
      chk("f0 frame_tick", 32'(frame_tick), (s == 24) ? 32'h1 : 32'h0);
      chk("fast an_n", 32'(an_n_f), 32'(AN_EXP[(s - 1) % 6]));
      chk("fast frame_tick", 32'(frame_tick_f), ((s % 6) == 0) ? 32'h1 : 32'h0);
      if (s == 1) chk("f0 seg_n d0", 32'(seg_n), 32'h40);
      if (s == 5) chk("f0 seg_n d1", 32'(seg_n), 32'h7F);
      if (s == 5) chk("f0 an_n d1", 32'(an_n), 32'h3D);
    end

    // Table: ports for vector i are loaded while vector i-1 is on display
    for (int i = 1; i < 4; i++) begin
      out_port0 = vecs[i].p0; out_port1 = vecs[i].p1; out_port2 = vecs[i].p2;
      run_frame(vecs[i - 1], 0, 32'h0);
    end
    out_port0 = vecs[0].p0; out_port1 = vecs[0].p1; out_port2 = vecs[0].p2;
    run_frame(vecs[3], 0, 32'h0);

    // Mid-frame store to port1 must not appear until the next boundary
    run_frame(vecs[0], 5, 32'h56);
    run_frame(v_chg, 0, 32'h0);

    // One-cycle reset during dig3 of a nonzero frame
    for (int s = 1; s <= 13; s++) step();
    chk("pre-rst an_n d3", 32'(an_n), 32'h37);
    clrn = 1'b0;
    step();
    chk_reset_outputs("midrst");
    clrn = 1'b1;
    run_frame(v_zero, 0, 32'h0);
    run_frame(v_chg, 0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
